// File: rtl/silife_pkg.sv
// Shared constants for the silife grid scheduler: sequencer state codes and counter widths.
package silife_pkg;

   typedef logic [1:0] seq_state_t;

   localparam seq_state_t IDLE  = 2'd0;
   localparam seq_state_t START = 2'd1;
   localparam seq_state_t GEN   = 2'd2;
   localparam seq_state_t WAIT  = 2'd3;

   localparam int unsigned GEN_COUNT_BITS = 16;

endpackage : silife_pkg

// File: rtl/silife_rr_arbiter2.sv
// Two-requester round-robin arbiter with registered grants and a registered, held address output.
module silife_rr_arbiter2 #(
   parameter int unsigned ADDR_BITS = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_req0,
   input  logic [ADDR_BITS-1:0] i_addr0,
   input  logic                 i_req1,
   input  logic [ADDR_BITS-1:0] i_addr1,
   output logic                 o_grant0,
   output logic                 o_grant1,
   output logic                 o_valid,
   output logic [ADDR_BITS-1:0] o_addr
);

   logic                 r_grant0;
   logic                 r_grant1;
   logic                 r_valid;
   logic [ADDR_BITS-1:0] r_addr;
   logic                 r_last1;   // 1: requester 1 was granted most recently

   logic                 w_win0;
   logic                 w_win1;

   // Requester 0 wins when alone or when requester 1 had the last grant on a tie.
   always_comb begin
      w_win0 = i_req0 && (!i_req1 || r_last1);
      w_win1 = i_req1 && !w_win0;
   end

   // Register the decision; the address and last-granted flag move only on an actual grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant0 <= 1'b0;
         r_grant1 <= 1'b0;
         r_valid  <= 1'b0;
         r_addr   <= '0;
         r_last1  <= 1'b1;
      end else begin
         r_grant0 <= w_win0;
         r_grant1 <= w_win1;
         r_valid  <= w_win0 || w_win1;
         if (w_win0) begin
            r_addr  <= i_addr0;
            r_last1 <= 1'b0;
         end else if (w_win1) begin
            r_addr  <= i_addr1;
            r_last1 <= 1'b1;
         end
      end
   end

   assign o_grant0 = r_grant0;
   assign o_grant1 = r_grant1;
   assign o_valid  = r_valid;
   assign o_addr   = r_addr;

endmodule : silife_rr_arbiter2

// File: rtl/silife_grid_scheduler.sv
// Paces life-grid generations, tracks the engine, counts generations and shares the row-read port.
module silife_grid_scheduler
   import silife_pkg::*;
#(
   parameter int unsigned HEIGHT      = 32,
   parameter int unsigned PERIOD_BITS = 24
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_run,
   input  logic                         i_step,
   input  logic [PERIOD_BITS-1:0]       i_period,
   output logic                         o_gen_start,
   input  logic                         i_gen_busy,
   input  logic                         i_gen_req,
   input  logic [$clog2(HEIGHT)-1:0]    i_gen_row,
   output logic                         o_gen_grant,
   input  logic                         i_disp_req,
   input  logic [$clog2(HEIGHT)-1:0]    i_disp_row,
   output logic                         o_disp_grant,
   output logic                         o_mem_rd,
   output logic [$clog2(HEIGHT)-1:0]    o_mem_row,
   output logic [GEN_COUNT_BITS-1:0]    o_generation,
   output logic                         o_busy
);

   localparam int unsigned ROW_BITS = $clog2(HEIGHT);

   seq_state_t                r_state;
   logic [PERIOD_BITS-1:0]    r_wait_cnt;
   logic [GEN_COUNT_BITS-1:0] r_generation;
   logic                      r_gen_armed;   // set after the first GEN cycle, whose busy is stale
   logic                      r_gen_start;
   logic                      r_busy;

   seq_state_t                w_state_next;
   logic [PERIOD_BITS-1:0]    w_wait_cnt_next;
   logic [GEN_COUNT_BITS-1:0] w_generation_next;
   logic                      w_gen_armed_next;

   // Sequencer next-state, period countdown and generation count.
   always_comb begin
      w_state_next      = r_state;
      w_wait_cnt_next   = r_wait_cnt;
      w_generation_next = r_generation;
      w_gen_armed_next  = r_gen_armed;
      case (r_state)
         IDLE: begin
            if (i_run || i_step) begin
               w_state_next = START;
            end
         end
         START: begin
            w_state_next     = GEN;
            w_gen_armed_next = 1'b0;
         end
         GEN: begin
            if (!r_gen_armed) begin
               w_gen_armed_next = 1'b1;
            end else if (!i_gen_busy) begin
               w_generation_next = r_generation + GEN_COUNT_BITS'(1);
               if (i_run) begin
                  w_state_next    = WAIT;
                  w_wait_cnt_next = i_period;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         WAIT: begin
            if (!i_run) begin
               w_state_next    = IDLE;
               w_wait_cnt_next = '0;
            end else if (r_wait_cnt == '0) begin
               w_state_next = START;
            end else begin
               w_wait_cnt_next = r_wait_cnt - PERIOD_BITS'(1);
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Sequencer state register; start pulse and busy are registered from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_wait_cnt   <= '0;
         r_generation <= '0;
         r_gen_armed  <= 1'b0;
         r_gen_start  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_wait_cnt   <= w_wait_cnt_next;
         r_generation <= w_generation_next;
         r_gen_armed  <= w_gen_armed_next;
         r_gen_start  <= (w_state_next == START);
         r_busy       <= (w_state_next == START) || (w_state_next == GEN);
      end
   end

   assign o_gen_start  = r_gen_start;
   assign o_busy       = r_busy;
   assign o_generation = r_generation;

   // Engine is requester 0 so it wins the first tie after reset.
   silife_rr_arbiter2 #(
      .ADDR_BITS (ROW_BITS)
   ) u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_req0   (i_gen_req),
      .i_addr0  (i_gen_row),
      .i_req1   (i_disp_req),
      .i_addr1  (i_disp_row),
      .o_grant0 (o_gen_grant),
      .o_grant1 (o_disp_grant),
      .o_valid  (o_mem_rd),
      .o_addr   (o_mem_row)
   );

endmodule : silife_grid_scheduler

// File: tb/tb_silife_grid_scheduler.sv
// Randomised self-checking bench for silife_grid_scheduler against a behavioural model.
module tb_silife_grid_scheduler;

   localparam int unsigned HEIGHT      = 32;
   localparam int unsigned PERIOD_BITS = 24;
   localparam int unsigned ROW_BITS    = $clog2(HEIGHT);

   logic                   clk;
   logic                   reset;
   logic                   i_run;
   logic                   i_step;
   logic [PERIOD_BITS-1:0] i_period;
   logic                   o_gen_start;
   logic                   i_gen_busy;
   logic                   i_gen_req;
   logic [ROW_BITS-1:0]    i_gen_row;
   logic                   o_gen_grant;
   logic                   i_disp_req;
   logic [ROW_BITS-1:0]    i_disp_row;
   logic                   o_disp_grant;
   logic                   o_mem_rd;
   logic [ROW_BITS-1:0]    o_mem_row;
   logic [15:0]            o_generation;
   logic                   o_busy;

   silife_grid_scheduler #(
      .HEIGHT      (HEIGHT),
      .PERIOD_BITS (PERIOD_BITS)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_run        (i_run),
      .i_step       (i_step),
      .i_period     (i_period),
      .o_gen_start  (o_gen_start),
      .i_gen_busy   (i_gen_busy),
      .i_gen_req    (i_gen_req),
      .i_gen_row    (i_gen_row),
      .o_gen_grant  (o_gen_grant),
      .i_disp_req   (i_disp_req),
      .i_disp_row   (i_disp_row),
      .o_disp_grant (o_disp_grant),
      .o_mem_rd     (o_mem_rd),
      .o_mem_row    (o_mem_row),
      .o_generation (o_generation),
      .o_busy       (o_busy)
   );

   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: a phase of the generation cycle, plus the shared-port owner history.
   localparam int PH_IDLE = 0, PH_LAUNCH = 1, PH_RUNNING = 2, PH_PAUSE = 3;
   int m_phase;
   int m_running_cycles;
   int m_pause_left;
   int m_gens;
   bit m_gg, m_dg, m_rd;
   int m_row;
   bit m_display_was_last;

   // Bench-side engine and requesters.
   int busy_left;
   int busy_len;
   bit auto_req;
   bit gen_pend, disp_pend;
   int cyc;
   int last_start;
   bit gap_en;
   int gap_exp;

   task automatic model_step();
      if (reset) begin
         m_phase = PH_IDLE; m_pause_left = 0; m_gens = 0; m_running_cycles = 0;
         m_gg = 0; m_dg = 0; m_rd = 0; m_row = 0; m_display_was_last = 1;
         return;
      end
      case (m_phase)
         PH_IDLE:   if (i_run || i_step) m_phase = PH_LAUNCH;
         PH_LAUNCH: begin m_phase = PH_RUNNING; m_running_cycles = 0; end
         PH_RUNNING: begin
            m_running_cycles++;
            if (m_running_cycles > 1 && !i_gen_busy) begin
               m_gens = (m_gens + 1) % 65536;
               if (i_run) begin m_phase = PH_PAUSE; m_pause_left = int'(i_period); end
               else m_phase = PH_IDLE;
            end
         end
         default: begin
            if (!i_run) m_phase = PH_IDLE;
            else if (m_pause_left == 0) m_phase = PH_LAUNCH;
            else m_pause_left--;
         end
      endcase
      // Port owner: sole requester, else whoever was not served last.
      m_gg = 0; m_dg = 0;
      if (i_gen_req && i_disp_req) begin
         if (m_display_was_last) m_gg = 1; else m_dg = 1;
      end else if (i_gen_req) m_gg = 1;
      else if (i_disp_req) m_dg = 1;
      m_rd = m_gg || m_dg;
      if (m_gg) begin m_row = int'(i_gen_row);  m_display_was_last = 0; end
      if (m_dg) begin m_row = int'(i_disp_row); m_display_was_last = 1; end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      check_val("gen_start",  int'(o_gen_start),  int'(m_phase == PH_LAUNCH));
      check_val("busy",       int'(o_busy),       int'(m_phase == PH_LAUNCH || m_phase == PH_RUNNING));
      check_val("generation", int'(o_generation), m_gens);
      check_val("gen_grant",  int'(o_gen_grant),  int'(m_gg));
      check_val("disp_grant", int'(o_disp_grant), int'(m_dg));
      check_val("mem_rd",     int'(o_mem_rd),     int'(m_rd));
      check_val("mem_row",    int'(o_mem_row),    m_row);
      if (gap_en && o_gen_start && last_start >= 0)
         check_val("start_gap", cyc - last_start, gap_exp);
      if (o_gen_start) last_start = cyc;
      // Engine raises busy the cycle after the start pulse.
      i_gen_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      if (o_gen_start) busy_left = busy_len;
      if (auto_req) begin
         if (o_gen_grant)  gen_pend  = 0;
         if (o_disp_grant) disp_pend = 0;
         if (!gen_pend && $urandom_range(0, 2) == 0) begin
            gen_pend = 1; i_gen_row = ROW_BITS'($urandom);
         end
         if (!disp_pend && $urandom_range(0, 2) == 0) begin
            disp_pend = 1; i_disp_row = ROW_BITS'($urandom);
         end
         i_gen_req  = gen_pend;
         i_disp_req = disp_pend;
      end
   endtask

   initial begin
      int g0;
      int starts;
      int exp_row;
      clk = 0; reset = 1; i_run = 0; i_step = 0; i_period = '0; i_gen_busy = 0;
      i_gen_req = 0; i_gen_row = '0; i_disp_req = 0; i_disp_row = '0;
      n_checks = 0; n_fail = 0; busy_left = 0; busy_len = 5; auto_req = 0;
      gen_pend = 0; disp_pend = 0; cyc = 0; last_start = -1; gap_en = 0; gap_exp = 0;
      m_phase = PH_IDLE; m_pause_left = 0; m_gens = 0; m_running_cycles = 0;
      m_gg = 0; m_dg = 0; m_rd = 0; m_row = 0; m_display_was_last = 1;

      #2;
      repeat (3) tick();
      reset = 0;
      tick();

      // Single step, engine busy 5 cycles.
      busy_len = 5;
      i_step = 1; tick(); i_step = 0;
      repeat (15) tick();
      check_val("step_count", int'(o_generation), 1);
      check_val("step_idle_busy", int'(o_busy), 0);

      // Free-running, period 10, busy 3: starts 16 cycles apart.
      busy_len = 3; i_period = PERIOD_BITS'(10); gap_exp = 16; last_start = -1; gap_en = 1;
      i_run = 1;
      repeat (60) tick();
      gap_en = 0;

      // Drop run in GEN: generation completes, then idle.
      for (int k = 0; k < 40 && !(o_busy && !o_gen_start); k++) tick();
      check_val("reach_gen", int'(o_busy && !o_gen_start), 1);
      g0 = int'(o_generation);
      i_run = 0;
      repeat (12) tick();
      check_val("drop_gen_count", int'(o_generation), (g0 + 1) % 65536);
      check_val("drop_gen_idle", int'(o_busy), 0);

      // Drop run in WAIT: idle at once, no further start.
      i_run = 1; g0 = int'(o_generation);
      for (int k = 0; k < 60 && int'(o_generation) == g0; k++) tick();
      check_val("reach_wait", int'(o_generation != 16'(g0)), 1);
      repeat (2) tick();
      i_run = 0;
      starts = 0;
      for (int k = 0; k < 20; k++) begin tick(); if (o_gen_start) starts++; end
      check_val("drop_wait_starts", starts, 0);

      // Both requesters held: rows alternate 3, 7 starting with the engine.
      i_gen_req = 1; i_gen_row = ROW_BITS'(3); i_disp_req = 1; i_disp_row = ROW_BITS'(7);
      tick();
      check_val("alt_first", int'(o_mem_row), 3);
      exp_row = 3;
      for (int k = 0; k < 7; k++) begin
         tick();
         exp_row = (exp_row == 3) ? 7 : 3;
         check_val("alt_row", int'(o_mem_row), exp_row);
      end

      // Display alone, engine joins and wins, then an idle cycle holds the row.
      i_gen_req = 0; i_disp_row = ROW_BITS'(5);
      repeat (2) tick();
      i_gen_req = 1; i_gen_row = ROW_BITS'(2);
      tick();
      check_val("join_eng", int'(o_gen_grant), 1);
      i_gen_req = 0; i_disp_req = 0;
      tick();
      check_val("idle_rd", int'(o_mem_rd), 0);
      check_val("hold_row", int'(o_mem_row), 2);

      // Reset during WAIT with a grant in flight; the first tie afterwards goes to the engine.
      busy_len = 1; i_period = PERIOD_BITS'(10); i_run = 1; g0 = int'(o_generation);
      i_gen_req = 1; i_gen_row = ROW_BITS'(9); i_disp_req = 1; i_disp_row = ROW_BITS'(12);
      for (int k = 0; k < 40 && int'(o_generation) == g0; k++) tick();
      check_val("reach_wait2", int'(o_generation != 16'(g0)), 1);
      tick();
      reset = 1; tick(); reset = 0; i_run = 0;
      check_val("rst_rd", int'(o_mem_rd), 0);
      check_val("rst_gen", int'(o_generation), 0);
      tick();
      check_val("tie_after_rst", int'(o_gen_grant), 1);

      // Randomised traffic.
      i_gen_req = 0; i_disp_req = 0; auto_req = 1; gen_pend = 0; disp_pend = 0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 29) == 0) i_run = ~i_run;
         i_step   = ($urandom_range(0, 7) == 0);
         i_period = PERIOD_BITS'($urandom_range(0, 6));
         busy_len = $urandom_range(1, 5);
         reset    = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_silife_grid_scheduler
